// File: rtl/tilelink_ul_master.sv
// TL-UL initiator: one outstanding A/D transaction, rolling source ID.
// Optional D-wait timeout enabled by defining TL_MASTER_TIMEOUT_EN.
module tilelink_ul_master #(
  parameter int TL_ADDR_WIDTH   = 64,
  parameter int TL_DATA_WIDTH   = 64,
  parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
  parameter int TL_SOURCE_WIDTH = 3,
  parameter int TL_SINK_WIDTH   = 3,
  parameter int TL_OPCODE_WIDTH = 3,
  parameter int TL_PARAM_WIDTH  = 3,
  parameter int TL_SIZE_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [TL_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [TL_SIZE_WIDTH-1:0]   cmd_size,
  input  logic [TL_STRB_WIDTH-1:0]   cmd_mask,
  input  logic [TL_DATA_WIDTH-1:0]   cmd_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [TL_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                       rsp_error,
  output logic                       a_valid,
  input  logic                       a_ready,
  output logic [TL_OPCODE_WIDTH-1:0] a_opcode,
  output logic [TL_PARAM_WIDTH-1:0]  a_param,
  output logic [TL_ADDR_WIDTH-1:0]   a_address,
  output logic [TL_SIZE_WIDTH-1:0]   a_size,
  output logic [TL_STRB_WIDTH-1:0]   a_mask,
  output logic [TL_DATA_WIDTH-1:0]   a_data,
  output logic [TL_SOURCE_WIDTH-1:0] a_source,
  input  logic                       d_valid,
  output logic                       d_ready,
  input  logic [TL_OPCODE_WIDTH-1:0] d_opcode,
  input  logic [TL_PARAM_WIDTH-1:0]  d_param,
  input  logic [TL_SIZE_WIDTH-1:0]   d_size,
  input  logic [TL_SINK_WIDTH-1:0]   d_sink,
  input  logic [TL_SOURCE_WIDTH-1:0] d_source,
  input  logic [TL_DATA_WIDTH-1:0]   d_data,
  input  logic                       d_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [TL_OPCODE_WIDTH-1:0] OP_PUT_FULL = 'd0;
  localparam logic [TL_OPCODE_WIDTH-1:0] OP_PUT_PART = 'd1;
  localparam logic [TL_OPCODE_WIDTH-1:0] OP_GET      = 'd4;
  localparam logic [TL_OPCODE_WIDTH-1:0] OP_ACK      = 'd0;
  localparam logic [TL_OPCODE_WIDTH-1:0] OP_ACK_DATA = 'd1;

  state_t                     state_q;
  logic [TL_OPCODE_WIDTH-1:0] a_opcode_q;
  logic [TL_ADDR_WIDTH-1:0]   a_address_q;
  logic [TL_SIZE_WIDTH-1:0]   a_size_q;
  logic [TL_STRB_WIDTH-1:0]   a_mask_q;
  logic [TL_DATA_WIDTH-1:0]   a_data_q;
  logic [TL_SOURCE_WIDTH-1:0] a_source_q;
  logic [TL_SOURCE_WIDTH-1:0] src_q;
  logic [TL_DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                       rsp_error_q;

  logic                       is_get;
  logic                       d_hit;
  logic [TL_OPCODE_WIDTH-1:0] exp_dop;
  logic [TL_OPCODE_WIDTH-1:0] cmd_op_d;
  logic [TL_DATA_WIDTH-1:0]   rdata_d;
  logic                       error_d;

  assign cmd_ready = (state_q == IDLE);
  assign a_valid   = (state_q == REQ);
  assign d_ready   = (state_q == WAIT);
  assign rsp_valid = (state_q == RESP);

  assign a_opcode  = a_opcode_q;
  assign a_param   = '0;
  assign a_address = a_address_q;
  assign a_size    = a_size_q;
  assign a_mask    = a_mask_q;
  assign a_data    = a_data_q;
  assign a_source  = a_source_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

  assign is_get  = (a_opcode_q == OP_GET);
  assign exp_dop = is_get ? OP_ACK_DATA : OP_ACK;
  assign d_hit   = d_valid && (d_source == a_source_q);
  assign rdata_d = is_get ? d_data : '0;
  assign error_d = d_error || (d_opcode != exp_dop);

  // Writes with every byte lane enabled become full puts.
  always_comb begin
    cmd_op_d = OP_GET;
    if (cmd_write) begin
      cmd_op_d = (&cmd_mask) ? OP_PUT_FULL : OP_PUT_PART;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{d_param, d_size, d_sink,
                       (TIMEOUT_CYCLES == 0)};

`ifdef TL_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q;
`endif

  // Transaction FSM with registered A payload and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_opcode_q  <= '0;
      a_address_q <= '0;
      a_size_q    <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
      a_source_q  <= '0;
      src_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
`ifdef TL_MASTER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q     <= REQ;
            a_opcode_q  <= cmd_op_d;
            a_address_q <= cmd_addr;
            a_size_q    <= cmd_size;
            a_mask_q    <= cmd_mask;
            a_data_q    <= cmd_write ? cmd_wdata : '0;
            a_source_q  <= src_q;
          end
        end
        REQ: begin
          if (a_ready) begin
            state_q <= WAIT;
            src_q   <= src_q + 1'b1;
`ifdef TL_MASTER_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end
        WAIT: begin
          if (d_hit) begin
            state_q     <= RESP;
            rsp_rdata_q <= rdata_d;
            rsp_error_q <= error_d;
          end
`ifdef TL_MASTER_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_q     <= RESP;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tilelink_ul_master.sv
// Directed vector bench for the TL-UL initiator.
// Default build; timeout sequence runs when TL_MASTER_TIMEOUT_EN is set.
module tb_tilelink_ul_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [63:0] cmd_addr;
  logic [7:0]  cmd_size;
  logic [7:0]  cmd_mask;
  logic [63:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [63:0] rsp_rdata;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param, a_source;
  logic [63:0] a_address, a_data;
  logic [7:0]  a_size, a_mask;
  logic        d_valid, d_ready, d_error;
  logic [2:0]  d_opcode, d_param, d_sink, d_source;
  logic [7:0]  d_size;
  logic [63:0] d_data;

  always #5 clk = ~clk;

  tilelink_ul_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_mask(cmd_mask),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_opcode(a_opcode), .a_param(a_param),
    .a_address(a_address), .a_size(a_size),
    .a_mask(a_mask), .a_data(a_data),
    .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_sink(d_sink),
    .d_source(d_source), .d_data(d_data),
    .d_error(d_error)
  );

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [7:0]  mask;
    logic [63:0] wdata;
    int          bp;
    logic [2:0]  dop;
    logic [63:0] ddata;
    logic        derr;
    logic        badsrc;
    int          hold;
    logic [2:0]  xop;
    logic [63:0] xrdata;
    logic        xerr;
  } vec_t;

  vec_t       v [9];
  int         checks = 0;
  int         errors = 0;
  int         hs_cnt = 0;
  logic [2:0] exp_src = 3'd0;
  logic [2:0] cur_src;

  always @(posedge clk) begin
    if (a_valid && a_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic issue(input vec_t t);
    int h0;
    logic [63:0] xd;
    xd = t.wr ? t.wdata : 64'd0;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_write = t.wr;
    cmd_addr = t.addr; cmd_size = 8'd3;
    cmd_mask = t.mask; cmd_wdata = t.wdata;
    @(negedge clk);
    cmd_valid = 0;
    chk("a_valid", a_valid, 1);
    chk("a_opcode", a_opcode, t.xop);
    chk("a_address", a_address, t.addr);
    chk("a_size", a_size, 3);
    chk("a_mask", a_mask, t.mask);
    chk("a_data", a_data, xd);
    chk("a_param", a_param, 0);
    chk("a_source", a_source, exp_src);
    chk("d_ready_req", d_ready, 0);
    h0 = hs_cnt;
    for (int k = 0; k < t.bp; k++) begin
      @(negedge clk);
      chk("bp_a_valid", a_valid, 1);
      chk("bp_a_opcode", a_opcode, t.xop);
      chk("bp_a_address", a_address, t.addr);
      chk("bp_a_data", a_data, xd);
      chk("bp_a_mask", a_mask, t.mask);
      chk("bp_a_source", a_source, exp_src);
    end
    a_ready = 1;
    @(negedge clk);
    a_ready = 0;
    chk("a_valid_drop", a_valid, 0);
    chk("d_ready_wait", d_ready, 1);
    chk("a_hs_count", hs_cnt - h0, 1);
    cur_src = exp_src;
    exp_src = exp_src + 3'd1;
  endtask

  task automatic finish_txn(input vec_t t);
    if (t.badsrc) begin
      d_valid = 1; d_source = cur_src + 3'd1;
      d_opcode = t.dop; d_data = 64'hBAD;
      d_error = 0;
      @(negedge clk);
      d_valid = 0;
      chk("badsrc_no_rsp", rsp_valid, 0);
      chk("badsrc_d_ready", d_ready, 1);
    end
    d_valid = 1; d_source = cur_src;
    d_opcode = t.dop; d_data = t.ddata;
    d_error = t.derr;
    @(negedge clk);
    d_valid = 0; d_error = 0;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, t.xrdata);
    chk("rsp_error", rsp_error, t.xerr);
    chk("d_ready_resp", d_ready, 0);
    for (int k = 0; k < t.hold; k++) begin
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, t.xrdata);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("rsp_valid_clear", rsp_valid, 0);
    chk("cmd_ready_back", cmd_ready, 1);
  endtask

  initial begin
    // wr addr mask wdata bp dop ddata derr badsrc hold xop xrdata xerr
    v[0] = '{1, 64'h100, 8'hFF, 64'hDEADBEEF, 0,
             3'd0, 64'h0, 0, 0, 0, 3'd0, 64'h0, 0};
    v[1] = '{1, 64'h108, 8'h0F, 64'h11223344, 5,
             3'd0, 64'h77, 0, 0, 0, 3'd1, 64'h0, 0};
    v[2] = '{0, 64'h200, 8'hFF, 64'h0, 0,
             3'd1, 64'h1234, 0, 0, 0, 3'd4, 64'h1234, 0};
    v[3] = '{0, 64'h208, 8'hF0, 64'h99, 1,
             3'd0, 64'h55, 0, 0, 0, 3'd4, 64'h55, 1};
    v[4] = '{1, 64'h300, 8'hFF, 64'hA5, 0,
             3'd0, 64'hFFFF, 1, 0, 0, 3'd0, 64'h0, 1};
    v[5] = '{1, 64'h308, 8'hFF, 64'h5A, 2,
             3'd1, 64'h0, 0, 0, 0, 3'd0, 64'h0, 1};
    v[6] = '{0, 64'h400, 8'hFF, 64'h0, 0,
             3'd1, 64'hCAFE, 0, 1, 0, 3'd4, 64'hCAFE, 0};
    v[7] = '{0, 64'h408, 8'h3C, 64'h0, 0,
             3'd1, 64'hA5A5, 0, 0, 4, 3'd4, 64'hA5A5, 0};
    v[8] = '{1, 64'h500, 8'h80, 64'h8000, 0,
             3'd0, 64'h0, 0, 0, 0, 3'd1, 64'h0, 0};

    rst = 1; cmd_valid = 0; cmd_write = 0;
    cmd_addr = 0; cmd_size = 0; cmd_mask = 0;
    cmd_wdata = 0; rsp_ready = 0; a_ready = 0;
    d_valid = 0; d_opcode = 0; d_param = 0;
    d_size = 0; d_sink = 0; d_source = 0;
    d_data = 0; d_error = 0;
    repeat (2) @(negedge clk);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_a_source", a_source, 0);
    chk("rst_a_address", a_address, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_error", rsp_error, 0);
    rst = 0;

    for (int i = 0; i < 9; i++) begin
      issue(v[i]);
      finish_txn(v[i]);
    end

    issue(v[2]);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_a_valid", a_valid, 0);
    chk("midrst_d_ready", d_ready, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_rsp_valid", rsp_valid, 0);
    d_valid = 1; d_source = cur_src;
    d_opcode = 3'd1; d_data = 64'h1234;
    @(negedge clk);
    d_valid = 0;
    chk("late_beat_rsp", rsp_valid, 0);
    chk("late_beat_idle", cmd_ready, 1);
    exp_src = 3'd0;
    issue(v[0]);
    finish_txn(v[0]);

`ifdef TL_MASTER_TIMEOUT_EN
    issue(v[2]);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("tmo_pending", rsp_valid, 0);
    end
    @(negedge clk);
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_rsp_error", rsp_error, 1);
    chk("tmo_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    issue(v[6]);
    d_valid = 1; d_source = cur_src - 3'd1;
    d_opcode = 3'd1; d_data = 64'hBEEF;
    @(negedge clk);
    d_valid = 0;
    chk("tmo_late_drop", rsp_valid, 0);
    finish_txn(v[2]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
